// File: rtl/work_cpkt_dispatch.sv
// Round-robin cell dispatcher: forwards CELL_LEN-beat cells to WRK_NUM workers and retires them in order.
// Optional statistics counters are built when WORK_DISPATCH_STAT_EN is defined.
module work_cpkt_dispatch #(
    parameter int unsigned WRK_NUM  = 8,
    parameter int unsigned DWID     = 256,
    parameter int unsigned CELL_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    input  logic [DWID-1:0]     in_data,
    output logic                in_rdy,
    output logic [WRK_NUM-1:0]  wrk_vld,
    output logic [DWID-1:0]     wrk_data,
    output logic                wrk_sop,
    output logic                wrk_eop,
    input  logic [WRK_NUM-1:0]  wrk_done,
    output logic                flag_wrk_exit,
    output logic [31:0]         cnt_cell_in,
    output logic [31:0]         cnt_cell_drop,
    output logic [31:0]         cnt_spur_done
);

    localparam int unsigned PW = $clog2(WRK_NUM);
    localparam int unsigned BW = $clog2(CELL_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(CELL_LEN - 1);

    logic [PW-1:0]      wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]      rd_ptr, rd_ptr_nxt;
    logic [BW-1:0]      beat_cnt, beat_cnt_nxt;
    logic [WRK_NUM-1:0] busy, busy_nxt;
    logic [WRK_NUM-1:0] done, done_nxt;
    logic               drop, drop_nxt;
    logic               exit_gap, exit_gap_nxt;
    logic [WRK_NUM-1:0] vld_nxt;
    logic               sop_nxt, eop_nxt, exit_nxt;
    logic               cell_drop, beat_last, retire;

    assign in_rdy = !busy[wr_ptr] && (beat_cnt == '0);

    // Drop decision is taken live on beat 0 and held in drop for the rest of the cell.
    assign cell_drop = (beat_cnt == '0) ? busy[wr_ptr] : drop;
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign retire    = busy[rd_ptr] && done[rd_ptr] && !exit_gap;

    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        beat_cnt_nxt = beat_cnt;
        busy_nxt     = busy;
        done_nxt     = done | (wrk_done & busy);
        drop_nxt     = drop;
        exit_gap_nxt = retire;
        exit_nxt     = retire;
        vld_nxt      = '0;
        sop_nxt      = 1'b0;
        eop_nxt      = 1'b0;

        if (retire) begin
            busy_nxt[rd_ptr] = 1'b0;
            done_nxt[rd_ptr] = 1'b0;
            rd_ptr_nxt       = rd_ptr + PW'(1);
        end

        if (in_vld) begin
            beat_cnt_nxt = beat_last ? '0 : beat_cnt + BW'(1);
            drop_nxt     = cell_drop;
            sop_nxt      = (beat_cnt == '0);
            eop_nxt      = beat_last;
            if (!cell_drop) begin
                vld_nxt = WRK_NUM'(1) << wr_ptr;
            end
            // Allocation applied after retirement so a new set on the same slot wins.
            if (beat_last && !cell_drop) begin
                busy_nxt[wr_ptr] = 1'b1;
                done_nxt[wr_ptr] = 1'b0;
                wr_ptr_nxt       = wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            beat_cnt      <= '0;
            busy          <= '0;
            done          <= '0;
            drop          <= 1'b0;
            exit_gap      <= 1'b0;
            wrk_vld       <= '0;
            wrk_data      <= '0;
            wrk_sop       <= 1'b0;
            wrk_eop       <= 1'b0;
            flag_wrk_exit <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            beat_cnt      <= beat_cnt_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            drop          <= drop_nxt;
            exit_gap      <= exit_gap_nxt;
            wrk_vld       <= vld_nxt;
            wrk_data      <= in_data;
            wrk_sop       <= sop_nxt;
            wrk_eop       <= eop_nxt;
            flag_wrk_exit <= exit_nxt;
        end
    end

`ifdef WORK_DISPATCH_STAT_EN
    localparam int unsigned SW = $clog2(WRK_NUM + 1);

    logic [31:0] cnt_in_q, cnt_drop_q, cnt_spur_q;
    logic [SW-1:0] spur_n;

    // Number of completion pulses landing on idle workers this cycle.
    always_comb begin
        spur_n = '0;
        for (int unsigned i = 0; i < WRK_NUM; i++) begin
            spur_n = spur_n + SW'(wrk_done[i] & ~busy[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_in_q   <= '0;
            cnt_drop_q <= '0;
            cnt_spur_q <= '0;
        end else begin
            if (in_vld && beat_last && !cell_drop) begin
                cnt_in_q <= cnt_in_q + 32'd1;
            end
            if (in_vld && (beat_cnt == '0) && busy[wr_ptr]) begin
                cnt_drop_q <= cnt_drop_q + 32'd1;
            end
            cnt_spur_q <= cnt_spur_q + 32'(spur_n);
        end
    end

    assign cnt_cell_in   = cnt_in_q;
    assign cnt_cell_drop = cnt_drop_q;
    assign cnt_spur_done = cnt_spur_q;
`else
    assign cnt_cell_in   = 32'd0;
    assign cnt_cell_drop = 32'd0;
    assign cnt_spur_done = 32'd0;
`endif

endmodule

// File: tb/tb_work_cpkt_dispatch.sv
// Directed bench for work_cpkt_dispatch: dispatch order, drops, in-order retirement, reset and wrap.
module tb_work_cpkt_dispatch;

    localparam int WRK_NUM  = 8;
    localparam int DWID     = 256;
    localparam int CELL_LEN = 4;
`ifdef WORK_DISPATCH_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_vld;
    logic [DWID-1:0]    in_data;
    logic               in_rdy;
    logic [WRK_NUM-1:0] wrk_vld;
    logic [DWID-1:0]    wrk_data;
    logic               wrk_sop;
    logic               wrk_eop;
    logic [WRK_NUM-1:0] wrk_done;
    logic               flag_wrk_exit;
    logic [31:0]        cnt_cell_in;
    logic [31:0]        cnt_cell_drop;
    logic [31:0]        cnt_spur_done;

    int compared   = 0;
    int mismatched = 0;
    int exit_cnt   = 0;
    int gap_err    = 0;
    bit prev_exit  = 1'b0;
    int sop_q[$];

    work_cpkt_dispatch #(
        .WRK_NUM (WRK_NUM),
        .DWID    (DWID),
        .CELL_LEN(CELL_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_data      (in_data),
        .in_rdy       (in_rdy),
        .wrk_vld      (wrk_vld),
        .wrk_data     (wrk_data),
        .wrk_sop      (wrk_sop),
        .wrk_eop      (wrk_eop),
        .wrk_done     (wrk_done),
        .flag_wrk_exit(flag_wrk_exit),
        .cnt_cell_in  (cnt_cell_in),
        .cnt_cell_drop(cnt_cell_drop),
        .cnt_spur_done(cnt_spur_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observer on the falling edge: exit pulses, back-to-back exit violations, worker of each sop.
    always @(negedge clk) begin
        if (flag_wrk_exit === 1'b1) begin
            exit_cnt++;
            if (prev_exit) gap_err++;
        end
        prev_exit = (flag_wrk_exit === 1'b1);
        if (wrk_sop === 1'b1) begin
            for (int i = 0; i < WRK_NUM; i++) begin
                if (wrk_vld[i] === 1'b1) sop_q.push_back(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_vld   = 1'b0;
        in_data  = '0;
        wrk_done = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_cell(input logic [31:0] tag, output logic [WRK_NUM-1:0] vld_or);
        vld_or = '0;
        for (int b = 0; b < CELL_LEN; b++) begin
            in_vld  = 1'b1;
            in_data = {8{tag + 32'(b)}};
            step();
            vld_or = vld_or | wrk_vld;
        end
        in_vld = 1'b0;
    endtask

    task automatic pulse_done(input logic [WRK_NUM-1:0] mask);
        wrk_done = mask;
        step();
        wrk_done = '0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (in_rdy !== 1'b1) begin
            mismatched++; $display("FAIL reset_in_rdy: got %b expected 1", in_rdy);
        end
        compared++;
        if (wrk_vld !== 8'h00 || wrk_sop !== 1'b0 || wrk_eop !== 1'b0 || flag_wrk_exit !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: vld=%h sop=%b eop=%b exit=%b expected all 0", wrk_vld, wrk_sop, wrk_eop, flag_wrk_exit);
        end
        compared++;
        if (wrk_data !== '0) begin
            mismatched++; $display("FAIL reset_data: got %h expected 0", wrk_data);
        end
        compared++;
        if (cnt_cell_in !== 32'd0 || cnt_cell_drop !== 32'd0 || cnt_spur_done !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_counters: in=%0d drop=%0d spur=%0d expected 0", cnt_cell_in, cnt_cell_drop, cnt_spur_done);
        end
    endtask

    task automatic test_single_cell();
        logic [DWID-1:0] exp_data;
        do_reset();
        for (int b = 0; b < CELL_LEN; b++) begin
            in_vld   = 1'b1;
            in_data  = {8{32'hA5A5_0000 + 32'(b)}};
            exp_data = in_data;
            step();
            compared++;
            if (wrk_vld !== 8'h01 || wrk_data !== exp_data) begin
                mismatched++; $display("FAIL single_beat%0d: vld=%h expected 01, data_ok=%b", b, wrk_vld, wrk_data === exp_data);
            end
            compared++;
            if (wrk_sop !== (b == 0) || wrk_eop !== (b == CELL_LEN - 1)) begin
                mismatched++; $display("FAIL single_sop_eop%0d: sop=%b eop=%b expected %b %b", b, wrk_sop, wrk_eop, b == 0, b == CELL_LEN - 1);
            end
        end
        in_vld = 1'b0;
        compared++;
        if (in_rdy !== 1'b1) begin
            mismatched++; $display("FAIL single_in_rdy: got %b expected 1", in_rdy);
        end
        step();
        compared++;
        if (wrk_vld !== 8'h00) begin
            mismatched++; $display("FAIL single_vld_idle: got %h expected 00", wrk_vld);
        end
        pulse_done(8'h01);
        compared++;
        if (flag_wrk_exit !== 1'b0) begin
            mismatched++; $display("FAIL exit_t1: got %b expected 0", flag_wrk_exit);
        end
        step();
        compared++;
        if (flag_wrk_exit !== 1'b1) begin
            mismatched++; $display("FAIL exit_t2: got %b expected 1", flag_wrk_exit);
        end
        step();
        compared++;
        if (flag_wrk_exit !== 1'b0) begin
            mismatched++; $display("FAIL exit_t3: got %b expected 0", flag_wrk_exit);
        end
        compared++;
        if (cnt_cell_in !== (STAT ? 32'd1 : 32'd0)) begin
            mismatched++; $display("FAIL single_cnt_in: got %0d expected %0d", cnt_cell_in, STAT ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [WRK_NUM-1:0] vo;
        do_reset();
        for (int c = 0; c < WRK_NUM; c++) begin
            send_cell(32'h1000 * 32'(c), vo);
            compared++;
            if (vo !== 8'(1 << c)) begin
                mismatched++; $display("FAIL b2b_cell%0d: vld=%h expected %h", c, vo, 8'(1 << c));
            end
        end
        compared++;
        if (in_rdy !== 1'b0) begin
            mismatched++; $display("FAIL full_in_rdy: got %b expected 0", in_rdy);
        end
        send_cell(32'hDEAD_0000, vo);
        step();
        compared++;
        if (vo !== 8'h00) begin
            mismatched++; $display("FAIL drop_vld: got %h expected 00", vo);
        end
        compared++;
        if (cnt_cell_drop !== (STAT ? 32'd1 : 32'd0) || cnt_cell_in !== (STAT ? 32'd8 : 32'd0)) begin
            mismatched++; $display("FAIL drop_counters: drop=%0d in=%0d expected %0d %0d", cnt_cell_drop, cnt_cell_in, STAT ? 1 : 0, STAT ? 8 : 0);
        end
        compared++;
        if (in_rdy !== 1'b0) begin
            mismatched++; $display("FAIL drop_in_rdy: got %b expected 0", in_rdy);
        end
    endtask

    task automatic test_done_order();
        logic [WRK_NUM-1:0] vo;
        int base;
        do_reset();
        for (int c = 0; c < 4; c++) send_cell(32'h2000 + 32'(c), vo);
        base = exit_cnt;
        pulse_done(8'h08);
        repeat (3) step();
        pulse_done(8'h02);
        repeat (3) step();
        compared++;
        if (exit_cnt - base !== 0) begin
            mismatched++; $display("FAIL order_early_exit: got %0d exits expected 0", exit_cnt - base);
        end
        base = exit_cnt;
        pulse_done(8'h01);
        pulse_done(8'h04);
        repeat (10) step();
        compared++;
        if (exit_cnt - base !== 4) begin
            mismatched++; $display("FAIL order_exits: got %0d expected 4", exit_cnt - base);
        end
        compared++;
        if (gap_err !== 0) begin
            mismatched++; $display("FAIL order_gap: got %0d adjacent exits expected 0", gap_err);
        end
    endtask

    task automatic test_spurious();
        int base;
        do_reset();
        base = exit_cnt;
        pulse_done(8'h20);
        repeat (4) step();
        compared++;
        if (exit_cnt - base !== 0) begin
            mismatched++; $display("FAIL spur_exit: got %0d exits expected 0", exit_cnt - base);
        end
        compared++;
        if (cnt_spur_done !== (STAT ? 32'd1 : 32'd0)) begin
            mismatched++; $display("FAIL spur_cnt: got %0d expected %0d", cnt_spur_done, STAT ? 1 : 0);
        end
    endtask

    task automatic test_mid_reset();
        logic [WRK_NUM-1:0] vo;
        do_reset();
        send_cell(32'h3000, vo);
        for (int b = 0; b < 2; b++) begin
            in_vld  = 1'b1;
            in_data = {8{32'h3100 + 32'(b)}};
            step();
        end
        in_data = {8{32'h3102}};
        rst_n   = 1'b0;
        step();
        rst_n  = 1'b1;
        in_vld = 1'b0;
        compared++;
        if (cnt_cell_in !== 32'd0 || cnt_cell_drop !== 32'd0 || cnt_spur_done !== 32'd0) begin
            mismatched++; $display("FAIL midrst_counters: in=%0d drop=%0d spur=%0d expected 0", cnt_cell_in, cnt_cell_drop, cnt_spur_done);
        end
        compared++;
        if (in_rdy !== 1'b1 || wrk_vld !== 8'h00) begin
            mismatched++; $display("FAIL midrst_state: in_rdy=%b vld=%h expected 1 00", in_rdy, wrk_vld);
        end
        sop_q.delete();
        send_cell(32'h3200, vo);
        compared++;
        if (vo !== 8'h01 || sop_q.size() !== 1) begin
            mismatched++; $display("FAIL midrst_fresh: vld=%h sops=%0d expected 01 1", vo, sop_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [WRK_NUM-1:0] vo;
        int base;
        do_reset();
        sop_q.delete();
        base = exit_cnt;
        for (int c = 0; c < 20; c++) begin
            send_cell(32'h4000 + 32'(c), vo);
            pulse_done(8'(1 << (c % WRK_NUM)));
        end
        repeat (8) step();
        compared++;
        if (sop_q.size() !== 20) begin
            mismatched++; $display("FAIL wrap_cells: got %0d expected 20", sop_q.size());
        end
        for (int c = 0; c < 20 && c < sop_q.size(); c++) begin
            compared++;
            if (sop_q[c] !== c % WRK_NUM) begin
                mismatched++; $display("FAIL wrap_worker%0d: got %0d expected %0d", c, sop_q[c], c % WRK_NUM);
            end
        end
        compared++;
        if (exit_cnt - base !== 20) begin
            mismatched++; $display("FAIL wrap_exits: got %0d expected 20", exit_cnt - base);
        end
        compared++;
        if (gap_err !== 0) begin
            mismatched++; $display("FAIL wrap_gap: got %0d adjacent exits expected 0", gap_err);
        end
        compared++;
        if (cnt_cell_in !== (STAT ? 32'd20 : 32'd0)) begin
            mismatched++; $display("FAIL wrap_cnt_in: got %0d expected %0d", cnt_cell_in, STAT ? 20 : 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_vld   = 1'b0;
        in_data  = '0;
        wrk_done = '0;
        test_reset();
        test_single_cell();
        test_back_to_back();
        test_done_order();
        test_spurious();
        test_mid_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
